serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 Port clk SHALL be an input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-004 Port start SHALL be an input, 1 bit: request to begin a subtraction, sampled only in IDLE.
REQ-005 Port a SHALL be an input, WIDTH bits: minuend, captured on the accepting edge.
REQ-006 Port b SHALL be an input, WIDTH bits: subtrahend, captured on the accepting edge.
REQ-007 Port busy SHALL be an output, 1 bit: high while state is RUN.
REQ-008 Port done SHALL be an output, 1 bit: one-cycle completion pulse.
REQ-009 Port diff SHALL be an output, WIDTH bits: registered result a-b mod 2^WIDTH.
REQ-010 Port borrow SHALL be an output, 1 bit: registered unsigned borrow-out, high when a<b.
REQ-011 Port ovf SHALL be an output, 1 bit: registered signed overflow flag, present only per REQ-026.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch a and b into shift registers, clear the internal borrow, set the bit counter to 0 and go to RUN.
REQ-014 In IDLE with start=0, the block SHALL stay in IDLE with all outputs held.
REQ-015 In RUN, each edge SHALL process one bit, LSB first: d = ai^bi^br and br' = (~ai&bi) | (~(ai^bi)&br).
REQ-016 In RUN, each edge SHALL shift d into the result shift register and increment the counter.
REQ-017 On the edge that processes bit WIDTH-1, the block SHALL load diff, borrow (and ovf) from the final values, assert done and go to DONE.
REQ-018 Latency SHALL be fixed: done is high in the cycle following the WIDTH-th edge after the accepting edge, independent of operand values.
REQ-019 DONE SHALL last exactly one cycle, then go to IDLE with done deasserted.
REQ-020 start SHALL be ignored in RUN and DONE; operands are not re-captured and no queued request is kept.
REQ-021 Changes on a and b after the accepting edge SHALL NOT affect the result.
REQ-022 diff, borrow and ovf SHALL change only on the completion edge and hold until the next completion or reset.
REQ-023 Wrap-around: a<b SHALL yield diff = a-b+2^WIDTH with borrow=1; a==b SHALL yield diff=0 with borrow=0.

Reset
REQ-024 With reset=1 at a rising edge, the block SHALL go to IDLE and clear busy, done, diff, borrow, ovf, the counter, the internal borrow and the shift registers, overriding all other inputs including start.
REQ-025 A reset in RUN or DONE SHALL abort the operation without any done pulse; the first start after reset deasserts is accepted normally.

Configuration
REQ-026 With macro SERIAL_SUB_OVF_EN defined, port ovf SHALL exist and equal (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]) for the captured operands, registered at completion and cleared by reset.
REQ-027 With SERIAL_SUB_OVF_EN undefined, port ovf and its logic SHALL be absent; all other behaviour and timing is identical.

Verification (WIDTH=8)
REQ-028 Basic: start with a=0x05, b=0x03 -> busy high 8 cycles, done pulses once on the 8th edge after acceptance, diff=0x02, borrow=0, ovf=0.
REQ-029 Wrap-around: a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0; a=0x00, b=0x00 -> diff=0x00, borrow=0.
REQ-030 Overflow (macro defined): a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
REQ-031 Ignored start: hold start=1 with new operands throughout RUN -> result matches the first operands only, exactly one done, then a new run starts from IDLE.
REQ-032 Reset mid-operation: reset on the 4th RUN cycle -> next cycle busy=0, done=0, diff=0x00, borrow=0, and no done appears later; a following start with a=0xFF, b=0x01 gives diff=0xFE.
REQ-033 Operand changes: change a and b every cycle after the accepting edge -> result equals the captured values (e.g. 0x10-0x20=0xF0, borrow=1).

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one result bit per clock, LSB first, fixed WIDTH-cycle latency.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] r_sr;
    logic [WIDTH-1:0] r_nx;
    logic             br;
    logic             ai;
    logic             bi;
    logic             d;
    logic             br_nx;
    logic             last;

    assign ai    = a_sr[0];
    assign bi    = b_sr[0];
    assign d     = ai ^ bi ^ br;
    assign br_nx = (~ai & bi) | (~(ai ^ bi) & br);
    assign last  = (cnt == CW'(WIDTH - 1));
    // Result bits arrive LSB first, so they enter at the top and drift down.
    assign r_nx  = {d, r_sr};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        r_sr <= '0;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_nx[WIDTH-1:1];
                    br   <= br_nx;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        diff   <= r_nx;
                        borrow <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
                        // Operand signs differ and the result sign left the minuend's.
                        ovf    <= (ai ^ bi) & (d ^ ai);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Randomized scoreboard bench for serial_sub (WIDTH=8).
// Expected results come from plain integer arithmetic; a monitor checks each done pulse.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_sub #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   busy_run = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        int   r;
        int   sa;
        int   sb;
        int   sr;
        r    = int'(av) - int'(bv);
        e.br = (r < 0);
        e.d  = W'((r + (1 << W)) % (1 << W));
        sa   = (int'(av) >= (1 << (W - 1))) ? int'(av) - (1 << W) : int'(av);
        sb   = (int'(bv) >= (1 << (W - 1))) ? int'(bv) - (1 << W) : int'(bv);
        sr   = sa - sb;
        e.ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (busy) busy_run = busy_run + 1;
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", 32'(diff), 32'(e.d));
                chk("borrow", 32'(borrow), 32'(e.br));
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.ov));
`endif
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("busy_cycles", 32'(busy_run), 32'(W));
                chk("busy_at_done", 32'(busy), 32'(0));
            end
        end
        if (!busy) busy_run = 0;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 4 * W) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy || done) chk("idle_timeout", 32'(1), 32'(0));
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit hold, input bit wiggle);
        exp_t e;
        @(posedge clk);
        #1;
        wait_idle();
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        e     = model(av, bv);
        e.cyc = cyc + W;
        q.push_back(e);
        start = hold;
        if (hold || wiggle) begin
            for (int i = 0; i < W + 1; i++) begin
                if (wiggle) begin
                    a = W'($urandom);
                    b = W'($urandom);
                end
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_clear(input string nm);
        chk({nm, "_busy"}, 32'(busy), 32'(0));
        chk({nm, "_done"}, 32'(done), 32'(0));
        chk({nm, "_diff"}, 32'(diff), 32'(0));
        chk({nm, "_borrow"}, 32'(borrow), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
        chk({nm, "_ovf"}, 32'(ovf), 32'(0));
`endif
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        check_clear("reset");
        reset = 1'b0;
        start = 1'b0;

        issue(8'h05, 8'h03, 1'b0, 1'b0);
        issue(8'h03, 8'h05, 1'b0, 1'b0);
        issue(8'h00, 8'h00, 1'b0, 1'b0);
        issue(8'h80, 8'h01, 1'b0, 1'b0);
        issue(8'h7F, 8'hFF, 1'b0, 1'b0);
        issue(8'hFF, 8'hFF, 1'b0, 1'b0);
        issue(8'h00, 8'hFF, 1'b0, 1'b0);

        issue(8'h21, 8'h12, 1'b1, 1'b1);
        issue(8'h10, 8'h20, 1'b0, 1'b1);
        issue(8'h44, 8'h40, 1'b0, 1'b0);

        // Abort in the 4th RUN cycle: no done may follow.
        issue(8'h11, 8'h22, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check_clear("abort");
        repeat (W + 4) @(posedge clk);
        #1;
        issue(8'hFF, 8'h01, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        for (int i = 0; i < 4 * W && q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_pending", 32'(q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
